// File: rtl/lb_pkg.sv
// Shared definitions for the dsp-domain local-bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lb_pkg;

  localparam int LB_AW = 24;
  localparam int LB_DW = 32;

  // Owner tag carried alongside each read through the return pipe.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // One captured master request.
  typedef struct packed {
    logic             rd;
    logic [LB_AW-1:0] addr;
    logic [LB_DW-1:0] wdata;
  } lb_req_t;

endpackage

// File: rtl/lb_req_hold.sv
// Per-master single-entry holding register with sticky overrun flag.
// Latency: a strobe is held (busy) from the edge after capture until taken.
// Backpressure: none upstream; a strobe while busy is dropped and flagged.
module lb_req_hold
  import lb_pkg::*;
#(
  parameter int aw = LB_AW,
  parameter int dw = LB_DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_strobe,
  input  logic          i_rd,
  input  logic [aw-1:0] i_addr,
  input  logic [dw-1:0] i_wdata,
  input  logic          i_take,
  input  logic          i_clr_overrun,
  output logic          o_busy,
  output logic          o_rd,
  output logic [aw-1:0] o_addr,
  output logic [dw-1:0] o_wdata,
  output logic          o_overrun
);

  logic          r_pend;
  logic          r_rd;
  logic [aw-1:0] r_addr;
  logic [dw-1:0] r_wdata;
  logic          r_ovr;

  // Capture into an empty slot, release on grant, flag strobes that land on a full slot.
  // Busy is the registered pending bit: a strobe in the take cycle is still a drop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend  <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (i_strobe && !r_pend) begin
        r_pend  <= 1'b1;
        r_rd    <= i_rd;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end else if (i_take) begin
        r_pend <= 1'b0;
      end
      // A drop in the same cycle as a clear wins, so no event is lost.
      r_ovr <= (r_ovr & ~i_clr_overrun) | (i_strobe & r_pend);
    end
  end

  assign o_busy    = r_pend;
  assign o_rd      = r_rd;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/lb_arbiter.sv
// Round-robin share of one local bus between two masters, read data routed back by owner tag.
// Latency: strobe->lb_strobe 2 clk min; lb_strobe(read)->rvalid read_lat+1 clk.
// Backpressure: busy per master; strobes while busy are dropped and set overrun.
module lb_arbiter
  import lb_pkg::*;
#(
  parameter int aw       = LB_AW,
  parameter int dw       = LB_DW,
  parameter int read_lat = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_strobe,
  input  logic          m0_rd,
  input  logic [aw-1:0] m0_addr,
  input  logic [dw-1:0] m0_wdata,
  output logic          m0_busy,
  output logic          m0_rvalid,
  output logic [dw-1:0] m0_rdata,
  input  logic          m1_strobe,
  input  logic          m1_rd,
  input  logic [aw-1:0] m1_addr,
  input  logic [dw-1:0] m1_wdata,
  output logic          m1_busy,
  output logic          m1_rvalid,
  output logic [dw-1:0] m1_rdata,
  output logic          lb_strobe,
  output logic          lb_rd,
  output logic [aw-1:0] lb_addr,
  output logic [dw-1:0] lb_data,
  input  logic [dw-1:0] lb_rdata,
  output logic [1:0]    overrun,
  input  logic          clr_overrun
);

  logic          w_busy0, w_busy1;
  logic          w_rd0, w_rd1;
  logic [aw-1:0] w_addr0, w_addr1;
  logic [dw-1:0] w_wdata0, w_wdata1;
  logic          w_ovr0, w_ovr1;
  logic          w_gnt0, w_gnt1;
  logic          w_ret_vld, w_ret_own;

  logic          r_lb_strobe;
  logic          r_lb_rd;
  logic [aw-1:0] r_lb_addr;
  logic [dw-1:0] r_lb_data;
  logic          r_last_grant;
  logic          r_issue_own;

  logic [read_lat-1:0] r_pipe_vld;
  logic [read_lat-1:0] r_pipe_own;

  logic          r_m0_rvalid, r_m1_rvalid;
  logic [dw-1:0] r_m0_rdata, r_m1_rdata;

  lb_req_hold #(.aw(aw), .dw(dw)) u_hold0 (
    .clk(clk), .rstn(rstn),
    .i_strobe(m0_strobe), .i_rd(m0_rd), .i_addr(m0_addr), .i_wdata(m0_wdata),
    .i_take(w_gnt0), .i_clr_overrun(clr_overrun),
    .o_busy(w_busy0), .o_rd(w_rd0), .o_addr(w_addr0), .o_wdata(w_wdata0),
    .o_overrun(w_ovr0)
  );

  lb_req_hold #(.aw(aw), .dw(dw)) u_hold1 (
    .clk(clk), .rstn(rstn),
    .i_strobe(m1_strobe), .i_rd(m1_rd), .i_addr(m1_addr), .i_wdata(m1_wdata),
    .i_take(w_gnt1), .i_clr_overrun(clr_overrun),
    .o_busy(w_busy1), .o_rd(w_rd1), .o_addr(w_addr1), .o_wdata(w_wdata1),
    .o_overrun(w_ovr1)
  );

  // Round-robin on registered pending bits: a lone requester always wins,
  // on contention the master not served last wins.
  assign w_gnt0 = w_busy0 & (~w_busy1 | (r_last_grant == M1));
  assign w_gnt1 = w_busy1 & (~w_busy0 | (r_last_grant == M0));

  // Issue register: one bus cycle per grant; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lb_strobe  <= 1'b0;
      r_lb_rd      <= 1'b0;
      r_lb_addr    <= '0;
      r_lb_data    <= '0;
      r_last_grant <= M1;
      r_issue_own  <= M0;
    end else begin
      r_lb_strobe <= w_gnt0 | w_gnt1;
      if (w_gnt1) begin
        r_lb_rd      <= w_rd1;
        r_lb_addr    <= w_addr1;
        r_lb_data    <= w_wdata1;
        r_last_grant <= M1;
        r_issue_own  <= M1;
      end else if (w_gnt0) begin
        r_lb_rd      <= w_rd0;
        r_lb_addr    <= w_addr0;
        r_lb_data    <= w_wdata0;
        r_last_grant <= M0;
        r_issue_own  <= M0;
      end
    end
  end

  // Tag pipe matched to the bus read latency; its last stage lines up with valid lb_rdata.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pipe_vld <= '0;
      r_pipe_own <= '0;
    end else begin
      r_pipe_vld[0] <= r_lb_strobe & r_lb_rd;
      r_pipe_own[0] <= r_issue_own;
      for (int i = 1; i < read_lat; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_own[i] <= r_pipe_own[i-1];
      end
    end
  end

  assign w_ret_vld = r_pipe_vld[read_lat-1];
  assign w_ret_own = r_pipe_own[read_lat-1];

  // Register the returning word into the owner's rdata; the other master's rdata holds.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_ret_vld & (w_ret_own == M0);
      r_m1_rvalid <= w_ret_vld & (w_ret_own == M1);
      if (w_ret_vld && (w_ret_own == M0)) r_m0_rdata <= lb_rdata;
      if (w_ret_vld && (w_ret_own == M1)) r_m1_rdata <= lb_rdata;
    end
  end

  assign m0_busy   = w_busy0;
  assign m1_busy   = w_busy1;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign lb_strobe = r_lb_strobe;
  assign lb_rd     = r_lb_rd;
  assign lb_addr   = r_lb_addr;
  assign lb_data   = r_lb_data;
  assign overrun   = {w_ovr1, w_ovr0};

endmodule

// File: tb/tb_lb_arbiter.sv
// Bench for lb_arbiter: directed scenarios plus a random soak against a transaction-level model.
// Latency: model predicts issue cycle and response cycle of every request.
// Backpressure: stimulus honours the model's view of busy except where drops are intended.
module tb_lb_arbiter;
  import lb_pkg::*;

  localparam int LAT = 3;

  typedef struct { lb_req_t req; int due; } lbx_t;
  typedef struct { logic [31:0] data; int due; } rsp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m0_strobe = 1'b0, m0_rd = 1'b0, m1_strobe = 1'b0, m1_rd = 1'b0;
  logic [23:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_busy, m0_rvalid, m1_busy, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        lb_strobe, lb_rd;
  logic [23:0] lb_addr;
  logic [31:0] lb_data;
  logic [31:0] lb_rdata = '0;
  logic [1:0]  overrun;
  logic        clr_overrun = 1'b0;

  lb_arbiter #(.aw(24), .dw(32), .read_lat(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .m0_strobe(m0_strobe), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_busy(m0_busy), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_strobe(m1_strobe), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_busy(m1_busy), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .lb_strobe(lb_strobe), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_data(lb_data),
    .lb_rdata(lb_rdata), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: one pending slot per master, last served master, sticky drop flags.
  bit          mp_vld [2];
  lb_req_t     mp_req [2];
  int          last_srv;
  logic [1:0]  ov;
  logic [1:0]  cur_busy;
  logic [1:0]  cur_ov;
  logic [31:0] mdl_rdata [2];
  logic [23:0] mdl_addr;
  logic [31:0] mdl_data;

  lbx_t lb_q[$];
  rsp_t rsp0_q[$];
  rsp_t rsp1_q[$];
  rsp_t rq[$];

  function automatic logic [31:0] rdval(input logic [23:0] a);
    return (a == 24'h300000) ? 32'hDEADBEAF : ({8'h00, a} ^ 32'h5A5A5A5A);
  endfunction

  function automatic lb_req_t mk(input logic rd, input logic [23:0] a, input logic [31:0] d);
    lb_req_t r;
    r.rd = rd; r.addr = a; r.wdata = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model works out what the coming edge must do.
  task automatic step(input bit s0, input lb_req_t r0, input bit s1, input lb_req_t r1, input bit clr);
    bit      s [2];
    lb_req_t r [2];
    int      w;
    lbx_t    x;
    rsp_t    p;
    s[0] = s0; s[1] = s1; r[0] = r0; r[1] = r1;
    m0_strobe = s0; m0_rd = r0.rd; m0_addr = r0.addr; m0_wdata = r0.wdata;
    m1_strobe = s1; m1_rd = r1.rd; m1_addr = r1.addr; m1_wdata = r1.wdata;
    clr_overrun = clr;
    cur_busy = {mp_vld[1], mp_vld[0]};
    cur_ov   = ov;
    if (mp_vld[0] || mp_vld[1]) begin
      if (mp_vld[0] && mp_vld[1]) w = (last_srv == 0) ? 1 : 0;
      else                        w = mp_vld[0] ? 0 : 1;
      x.req = mp_req[w]; x.due = cyc + 1;
      lb_q.push_back(x);
      if (mp_req[w].rd) begin
        p.data = rdval(mp_req[w].addr); p.due = cyc + 2 + LAT;
        if (w == 0) rsp0_q.push_back(p); else rsp1_q.push_back(p);
      end
      mp_vld[w] = 1'b0;
      last_srv  = w;
    end
    if (clr) ov = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (s[i]) begin
        if (cur_busy[i]) ov[i] = 1'b1;
        else begin mp_vld[i] = 1'b1; mp_req[i] = r[i]; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, mk(0, 0, 0), 1'b0, mk(0, 0, 0), 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; chk_en = 1'b0;
    m0_strobe = 1'b0; m1_strobe = 1'b0; clr_overrun = 1'b0;
    @(posedge clk); #1;
    mp_vld[0] = 1'b0; mp_vld[1] = 1'b0; last_srv = 1; ov = 2'b00;
    cur_busy = 2'b00; cur_ov = 2'b00;
    mdl_rdata[0] = '0; mdl_rdata[1] = '0; mdl_addr = '0; mdl_data = '0;
    lb_q.delete(); rsp0_q.delete(); rsp1_q.delete(); rq.delete();
    chk("rst_lb_strobe", 64'(lb_strobe), 64'(0));
    chk("rst_lb_rd",     64'(lb_rd),     64'(0));
    chk("rst_lb_addr",   64'(lb_addr),   64'(0));
    chk("rst_lb_data",   64'(lb_data),   64'(0));
    chk("rst_rvalid",    64'({m1_rvalid, m0_rvalid}), 64'(0));
    chk("rst_m0_rdata",  64'(m0_rdata),  64'(0));
    chk("rst_m1_rdata",  64'(m1_rdata),  64'(0));
    chk("rst_busy",      64'({m1_busy, m0_busy}), 64'(0));
    chk("rst_overrun",   64'(overrun),   64'(0));
    rstn = 1'b1; chk_en = 1'b1;
  endtask

  task automatic mon_rsp(input int i, input logic v, input logic [31:0] d);
    rsp_t h;
    bit   have;
    have = (i == 0) ? (rsp0_q.size() > 0) : (rsp1_q.size() > 0);
    if (have) h = (i == 0) ? rsp0_q[0] : rsp1_q[0];
    if (v) begin
      if (!have) chk($sformatf("m%0d_rvalid_unexpected", i), 64'(v), 64'(have));
      else begin
        if (i == 0) void'(rsp0_q.pop_front()); else void'(rsp1_q.pop_front());
        chk($sformatf("m%0d_rvalid_cycle", i), 64'(cyc), 64'(h.due));
        chk($sformatf("m%0d_rdata", i), 64'(d), 64'(h.data));
        mdl_rdata[i] = h.data;
      end
    end else begin
      if (have && h.due <= cyc) begin
        chk($sformatf("m%0d_rvalid_missing", i), 64'(v), 64'(1));
        if (i == 0) void'(rsp0_q.pop_front()); else void'(rsp1_q.pop_front());
      end
      chk($sformatf("m%0d_rdata_hold", i), 64'(d), 64'(mdl_rdata[i]));
    end
  endtask

  // Bus slave with fixed read latency, then the scoreboard monitor.
  always @(negedge clk) begin
    lbx_t h;
    rsp_t e;
    if (rstn && lb_strobe && lb_rd) begin
      e.data = rdval(lb_addr); e.due = cyc + LAT;
      rq.push_back(e);
    end
    if (rq.size() > 0 && rq[0].due == cyc) lb_rdata = rq.pop_front().data;
    else                                   lb_rdata = $urandom;
    if (chk_en) begin
      if (lb_strobe) begin
        if (lb_q.size() == 0) chk("lb_strobe_unexpected", 64'(lb_strobe), 64'(0));
        else begin
          h = lb_q.pop_front();
          chk("lb_issue_cycle", 64'(cyc), 64'(h.due));
          chk("lb_rd",   64'(lb_rd),   64'(h.req.rd));
          chk("lb_addr", 64'(lb_addr), 64'(h.req.addr));
          chk("lb_data", 64'(lb_data), 64'(h.req.wdata));
          mdl_addr = h.req.addr; mdl_data = h.req.wdata;
        end
      end else begin
        if (lb_q.size() > 0 && lb_q[0].due <= cyc) begin
          chk("lb_strobe_missing", 64'(lb_strobe), 64'(1));
          void'(lb_q.pop_front());
        end
        chk("lb_addr_hold", 64'(lb_addr), 64'(mdl_addr));
        chk("lb_data_hold", 64'(lb_data), 64'(mdl_data));
      end
      mon_rsp(0, m0_rvalid, m0_rdata);
      mon_rsp(1, m1_rvalid, m1_rdata);
      chk("busy",    64'({m1_busy, m0_busy}), 64'(cur_busy));
      chk("overrun", 64'(overrun), 64'(cur_ov));
    end
  end

  initial begin
    lb_req_t q0, q1;
    int      n_str;
    bit      s0, s1;
    do_reset();
    idle(2);

    // Single write from m0.
    step(1'b1, mk(0, 24'h010002, 32'h3FF), 1'b0, mk(0, 0, 0), 1'b0);
    idle(6);

    // Single read from m1 (slave returns DEADBEAF for this address).
    step(1'b0, mk(0, 0, 0), 1'b1, mk(1, 24'h300000, 32'h0), 1'b0);
    idle(8);

    // Three contention occasions, both masters reading in the same cycle.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, mk(1, 24'h000100 + 24'(k), 32'h11), 1'b1, mk(1, 24'h000200 + 24'(k), 32'h22), 1'b0);
      idle(1);
    end
    idle(8);

    // Overrun: back-to-back m0 strobes, clear, then clear racing a fresh drop.
    step(1'b1, mk(0, 24'h000A00, 32'hA0), 1'b0, mk(0, 0, 0), 1'b0);
    step(1'b1, mk(0, 24'h000A01, 32'hA1), 1'b0, mk(0, 0, 0), 1'b0);
    idle(4);
    step(1'b0, mk(0, 0, 0), 1'b0, mk(0, 0, 0), 1'b1);
    idle(2);
    step(1'b1, mk(0, 24'h000B00, 32'hB0), 1'b0, mk(0, 0, 0), 1'b0);
    step(1'b1, mk(0, 24'h000B01, 32'hB1), 1'b0, mk(0, 0, 0), 1'b1);
    idle(4);
    step(1'b0, mk(0, 0, 0), 1'b0, mk(0, 0, 0), 1'b1);
    idle(6);

    // Reset one cycle after a read's bus strobe: the response must never appear.
    step(1'b0, mk(0, 0, 0), 1'b1, mk(1, 24'h123456, 32'h0), 1'b0);
    idle(2);
    do_reset();
    idle(8);
    step(1'b1, mk(1, 24'h000300, 32'h33), 1'b1, mk(0, 24'h000400, 32'h44), 1'b0);
    idle(8);

    // Random soak honouring busy.
    n_str = 0;
    while (n_str < 10000) begin
      s0 = !mp_vld[0] && ($urandom_range(0, 1) == 1);
      s1 = !mp_vld[1] && ($urandom_range(0, 1) == 1);
      q0 = mk(1'($urandom_range(0, 1)), 24'($urandom), $urandom);
      q1 = mk(1'($urandom_range(0, 1)), 24'($urandom), $urandom);
      step(s0, q0, s1, q1, 1'b0);
      n_str += int'(s0) + int'(s1);
    end

    // Drain within a bounded number of cycles.
    for (int i = 0; i < 40 && (lb_q.size() + rsp0_q.size() + rsp1_q.size()) > 0; i++) idle(1);
    idle(2);
    chk("queues_drained", 64'(lb_q.size() + rsp0_q.size() + rsp1_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
